// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
// Read-latency encodings and an elaboration-time log2 helper.
package fifo_pkg;

    localparam int LAT_FWFT = 0;
    localparam int LAT_STD  = 1;

    // Bits needed to encode 0..value-1; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Register FIFO used as the prefetch skid buffer of fifo_rd_stream.
// Occupancy is a separate counter; pointers wrap on their own width.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    localparam int LW        = clog2(DEPTH + 1),
    localparam int AW        = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [LW-1:0]         level
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_pop;

    assign do_pop = pop && (level != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port into a valid/ready stream, hiding read latency
// with a credit-limited prefetch into a small skid buffer.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 4,
    localparam int LW        = clog2(BUF_DEPTH + 1)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LW-1:0]         buf_level
);

    localparam int IW = (RD_LATENCY > 0) ? clog2(RD_LATENCY + 1) : 1;
    localparam int CW = LW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(BUF_DEPTH);

    if (RD_LATENCY < 0 || RD_LATENCY > 3) begin : g_bad_lat
        $error("fifo_rd_stream: RD_LATENCY must be 0..3");
    end
    if (BUF_DEPTH < 2 || BUF_DEPTH < RD_LATENCY + 1 ||
        (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_rd_stream: BUF_DEPTH must be a power of 2 >= RD_LATENCY+1");
    end

    logic          capture;
    logic          pop;
    logic [IW-1:0] inflight;
    logic [CW-1:0] committed;

    // Credit uses registered counts only, so m_ready never reaches fifo_rd_en.
    assign committed  = CW'(buf_level) + CW'(inflight);
    assign fifo_rd_en = !rd_rst && !fifo_empty &&
                        (committed < CW'(BUF_DEPTH));

    assign m_valid = (buf_level != '0);
    assign pop     = m_valid && m_ready;

    if (RD_LATENCY == LAT_FWFT) begin : g_fwft
        assign capture  = fifo_rd_en;
        assign inflight = '0;
    end else begin : g_pipe
        logic [RD_LATENCY-1:0] vld_pipe;

        assign capture = vld_pipe[RD_LATENCY-1];

        always_ff @(posedge rd_clk) begin
            if (rd_rst) begin
                vld_pipe <= '0;
                inflight <= '0;
            end else begin
                vld_pipe <= RD_LATENCY'({vld_pipe, fifo_rd_en});
                case ({fifo_rd_en, capture})
                    2'b10:   inflight <= inflight + 1'b1;
                    2'b01:   inflight <= inflight - 1'b1;
                    default: inflight <= inflight;
                endcase
            end
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (BUF_DEPTH)
    ) u_buf (
        .clk      (rd_clk),
        .rst      (rd_rst),
        .push     (capture),
        .push_data(fifo_rd_data),
        .pop      (pop),
        .head     (m_data),
        .level    (buf_level)
    );

    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            assert (!(capture && !pop && buf_level == FULL_LVL))
            else $error("fifo_rd_stream: capture into a full skid buffer");
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a Standard (latency 1, depth 4) and an FWFT
// (latency 0, depth 2) instance, each fed by a queue-based FIFO model.
module tb_fifo_rd_stream;

    typedef struct {
        logic [15:0] w;
        int          arr;
    } ent_t;

    typedef struct {
        logic        mrdy;
        logic        en;
        logic        vld;
        logic [15:0] data;
        int          lvl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        empty [2];
    logic        rd_en [2];
    logic [15:0] rdata [2];
    logic        vld   [2];
    logic        mrdy  [2];
    logic [15:0] mdata [2];
    logic [2:0]  lvl0;
    logic [1:0]  lvl1;

    logic        gate    [2];
    logic        last_en [2];
    logic [15:0] pend0;
    int          e = 0;
    int          checks = 0;
    int          failures = 0;

    logic [15:0] src  [2][$];
    ent_t        sent [2][$];
    logic [15:0] got  [2][$];
    logic [15:0] rec  [2][$];
    vec_t        tv   [$];

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(16), .RD_LATENCY(1), .BUF_DEPTH(4)) u_std (
        .rd_clk(clk), .rd_rst(rst[0]), .fifo_empty(empty[0]),
        .fifo_rd_en(rd_en[0]), .fifo_rd_data(rdata[0]),
        .m_valid(vld[0]), .m_ready(mrdy[0]), .m_data(mdata[0]),
        .buf_level(lvl0)
    );

    fifo_rd_stream #(.DATA_WIDTH(16), .RD_LATENCY(0), .BUF_DEPTH(2)) u_fwft (
        .rd_clk(clk), .rd_rst(rst[1]), .fifo_empty(empty[1]),
        .fifo_rd_en(rd_en[1]), .fifo_rd_data(rdata[1]),
        .m_valid(vld[1]), .m_ready(mrdy[1]), .m_data(mdata[1]),
        .buf_level(lvl1)
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic int level_of(input int d);
        return (d == 0) ? int'(lvl0) : int'(lvl1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic push_word(input int d, input logic [15:0] w);
        src[d].push_back(w);
        rec[d].push_back(w);
    endtask

    task automatic add_vec(input logic r, input logic en, input logic v,
                           input logic [15:0] data, input int l);
        vec_t t;
        t.mrdy = r; t.en = en; t.vld = v; t.data = data; t.lvl = l;
        tv.push_back(t);
    endtask

    // One clock: present FIFO-model outputs, check the read strobe against
    // the credit rule, account reads/pops, then check outputs after the edge.
    task automatic cyc();
        logic exp_en;
        ent_t ent;
        int   n;
        for (int d = 0; d < 2; d++) begin
            empty[d] = gate[d] || (src[d].size() == 0);
        end
        rdata[0] = pend0;
        rdata[1] = (src[1].size() != 0) ? src[1][0] : 16'h0;
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_en = !rst[d] && !empty[d] && (sent[d].size() < depth_of(d));
            chk($sformatf("rd_en%0d", d), int'(rd_en[d]), int'(exp_en));
            last_en[d] = rd_en[d];
            if (rst[d]) begin
                sent[d].delete();
            end else begin
                if (vld[d] && mrdy[d] && sent[d].size() != 0) begin
                    got[d].push_back(mdata[d]);
                    void'(sent[d].pop_front());
                end
                if (rd_en[d] && src[d].size() != 0) begin
                    ent.w   = src[d].pop_front();
                    ent.arr = e + 1 + lat_of(d);
                    sent[d].push_back(ent);
                    if (d == 0) pend0 = ent.w;
                end
            end
        end
        @(negedge clk);
        e++;
        for (int d = 0; d < 2; d++) begin
            n = 0;
            for (int i = 0; i < sent[d].size(); i++) begin
                if (sent[d][i].arr <= e) n++;
            end
            chk($sformatf("level%0d", d), level_of(d), n);
            chk($sformatf("valid%0d", d), int'(vld[d]), int'(n != 0));
            if (n != 0) begin
                chk($sformatf("data%0d", d), int'(mdata[d]), int'(sent[d][0].w));
            end
        end
    endtask

    task automatic cmp_stream(input int d, input string name);
        chk({name, "_count"}, got[d].size(), rec[d].size());
        for (int i = 0; i < got[d].size() && i < rec[d].size(); i++) begin
            chk($sformatf("%s_word%0d", name, i), int'(got[d][i]), int'(rec[d][i]));
        end
        got[d].delete();
        rec[d].delete();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((src[0].size() + src[1].size() + sent[0].size() +
                sent[1].size()) != 0 && k < 100) begin
            cyc();
            k++;
        end
        chk({name, "_drain_timeout"}, int'(k >= 100), 0);
    endtask

    initial begin
        int cnt;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; gate[d] = 1'b0; mrdy[d] = 1'b1;
            empty[d] = 1'b1; rdata[d] = '0; last_en[d] = 1'b0;
        end
        pend0 = '0;

        // Reset state
        cyc();
        cyc();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid%0d", d), int'(vld[d]), 0);
            chk($sformatf("rst_level%0d", d), level_of(d), 0);
            chk($sformatf("rst_data%0d", d), int'(mdata[d]), 0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Latency: read in cycle 10, word visible after edge 11
        while (e < 9) cyc();
        push_word(0, 16'h0005);
        cyc();
        chk("lat_rd_en_c10", int'(last_en[0]), 1);
        chk("lat_valid_e10", int'(vld[0]), 0);
        cyc();
        chk("lat_valid_e11", int'(vld[0]), 1);
        chk("lat_data_e11", int'(mdata[0]), 16'h0005);
        drain("lat");
        cmp_stream(0, "lat");

        // Throughput: 8 reads back to back, 8 consecutive output words
        for (int i = 0; i < 8; i++) push_word(0, 16'(i));
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (last_en[0]) cnt++;
            chk($sformatf("thr_en%0d", i), int'(last_en[0]), int'(i < 8));
            chk($sformatf("thr_valid%0d", i), int'(vld[0]), int'(i >= 1 && i <= 8));
        end
        chk("thr_en_count", cnt, 8);
        cmp_stream(0, "thr");

        // Back-pressure, table driven
        add_vec(0, 1, 0, 16'd0, 0);
        add_vec(0, 1, 1, 16'd0, 1);
        add_vec(0, 1, 1, 16'd0, 2);
        add_vec(0, 1, 1, 16'd0, 3);
        add_vec(0, 0, 1, 16'd0, 4);
        add_vec(0, 0, 1, 16'd0, 4);
        add_vec(0, 0, 1, 16'd0, 4);
        add_vec(1, 0, 1, 16'd1, 3);
        add_vec(1, 1, 1, 16'd2, 2);
        add_vec(1, 1, 1, 16'd3, 2);
        add_vec(1, 1, 1, 16'd4, 2);
        add_vec(1, 1, 1, 16'd5, 2);
        add_vec(1, 1, 1, 16'd6, 2);
        add_vec(1, 1, 1, 16'd7, 2);
        add_vec(1, 0, 1, 16'd8, 2);
        add_vec(1, 0, 1, 16'd9, 1);
        add_vec(1, 0, 0, 16'd0, 0);
        for (int i = 0; i < 10; i++) push_word(0, 16'(i));
        for (int r = 0; r < tv.size(); r++) begin
            mrdy[0] = tv[r].mrdy;
            cyc();
            chk($sformatf("bp_en_r%0d", r), int'(last_en[0]), int'(tv[r].en));
            chk($sformatf("bp_valid_r%0d", r), int'(vld[0]), int'(tv[r].vld));
            chk($sformatf("bp_level_r%0d", r), level_of(0), tv[r].lvl);
            if (tv[r].vld) begin
                chk($sformatf("bp_data_r%0d", r), int'(mdata[0]), int'(tv[r].data));
            end
        end
        cmp_stream(0, "bp");

        // Sparse source: empty flag toggles every cycle
        for (int i = 0; i < 12; i++) push_word(0, 16'($urandom));
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (src[0].size() == 0 && sent[0].size() == 0) break;
            gate[0] = ~gate[0];
            cyc();
            if (last_en[0] && empty[0]) cnt++;
        end
        gate[0] = 1'b0;
        drain("sparse");
        chk("sparse_en_when_empty", cnt, 0);
        cmp_stream(0, "sparse");

        // Reset mid-burst with level 3 and one read in flight
        mrdy[0] = 1'b0;
        for (int i = 0; i < 10; i++) push_word(0, 16'h0100 + 16'(i));
        for (int i = 0; i < 4; i++) cyc();
        chk("rmb_level_before", level_of(0), 3);
        chk("rmb_committed_before", sent[0].size(), 4);
        rst[0] = 1'b1;
        src[0].delete();
        cyc();
        chk("rmb_rd_en", int'(last_en[0]), 0);
        chk("rmb_valid", int'(vld[0]), 0);
        chk("rmb_level", level_of(0), 0);
        chk("rmb_data", int'(mdata[0]), 0);
        rst[0] = 1'b0;
        mrdy[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("rmb_level_after%0d", i), level_of(0), 0);
        end
        got[0].delete();
        rec[0].delete();

        // FWFT: word visible after the same edge as its read
        for (int i = 0; i < 5; i++) push_word(1, 16'(i));
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("fwft_en%0d", i), int'(last_en[1]), 1);
            chk($sformatf("fwft_valid%0d", i), int'(vld[1]), 1);
            chk($sformatf("fwft_data%0d", i), int'(mdata[1]), i);
        end
        cyc();
        chk("fwft_valid_end", int'(vld[1]), 0);
        cmp_stream(1, "fwft");

        // Random source gaps and back-pressure on both instances
        for (int k = 0; k < 400; k++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 2) == 0 && rec[d].size() < 80) begin
                    push_word(d, 16'($urandom));
                end
                gate[d] = ($urandom_range(0, 3) == 0);
                mrdy[d] = ($urandom_range(0, 3) != 0);
            end
            cyc();
        end
        for (int d = 0; d < 2; d++) begin
            gate[d] = 1'b0;
            mrdy[d] = 1'b1;
        end
        drain("rnd");
        cmp_stream(0, "rnd_std");
        cmp_stream(1, "rnd_fwft");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
